// File: rtl/conversor_reg_bcd_reg_nbits_if.sv
// Start/done handshake and operand/result bus of the BCD-to-binary converter.
// The master issues the BCD operand; the slave returns the binary result and status flags.
interface conversor_reg_bcd_reg_nbits_if #(
  parameter int TAM_REG_BIN = 16
);
  logic                     inicio;
  logic [TAM_REG_BIN+3:0]   reg_BCD;
  logic [TAM_REG_BIN-1:0]   reg_binario;
  logic                     ocupado;
  logic                     listo;
  logic                     error_digito;
  logic                     desborde;

  modport master (
    output inicio, reg_BCD,
    input  reg_binario, ocupado, listo, error_digito, desborde
  );

  modport slave (
    input  inicio, reg_BCD,
    output reg_binario, ocupado, listo, error_digito, desborde
  );
endinterface

// File: rtl/conversor_reg_bcd_reg_nbits.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Digits above 9 abort straight to FIN with error_digito; a nonzero BCD residue means overflow.
module conversor_reg_bcd_reg_nbits #(
  parameter int TAM_REG_BIN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  conversor_reg_bcd_reg_nbits_if.slave  bus
);
  localparam int BW = TAM_REG_BIN + 4;
  localparam int ND = BW / 4;
  localparam int CW = $clog2(TAM_REG_BIN);

  typedef enum logic [1:0] {REPOSO, CONVIRTIENDO, FIN} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [TAM_REG_BIN-1:0] bin_q, bin_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [TAM_REG_BIN-1:0] reg_binario_q, reg_binario_d;
  logic                   ocupado_q, ocupado_d;
  logic                   listo_q, listo_d;
  logic                   error_digito_q, error_digito_d;
  logic                   desborde_q, desborde_d;

  function automatic logic digit_invalid(input logic [BW-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // Inverse of the add-3 step: a digit that reached 8 or more after the shift had borrowed 5
  function automatic logic [BW-1:0] ajustar(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    bcd_d          = bcd_q;
    bin_d          = bin_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    reg_binario_d  = reg_binario_q;
    ocupado_d      = ocupado_q;
    listo_d        = 1'b0;
    error_digito_d = error_digito_q;
    desborde_d     = desborde_q;

    case (state_q)
      REPOSO: begin
        if (bus.inicio) begin
          bcd_d     = bus.reg_BCD;
          bin_d     = '0;
          cnt_d     = '0;
          err_d     = digit_invalid(bus.reg_BCD);
          ocupado_d = 1'b1;
          state_d   = err_d ? FIN : CONVIRTIENDO;
        end
      end
      CONVIRTIENDO: begin
        bin_d = {bcd_q[0], bin_q[TAM_REG_BIN-1:1]};
        bcd_d = ajustar({1'b0, bcd_q[BW-1:1]});
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TAM_REG_BIN - 1)) state_d = FIN;
      end
      FIN: begin
        reg_binario_d  = err_q ? '0 : bin_q;
        error_digito_d = err_q;
        desborde_d     = !err_q && (bcd_q != '0);
        listo_d        = 1'b1;
        ocupado_d      = 1'b0;
        state_d        = REPOSO;
      end
      default: state_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= REPOSO;
      bcd_q          <= '0;
      bin_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      reg_binario_q  <= '0;
      ocupado_q      <= 1'b0;
      listo_q        <= 1'b0;
      error_digito_q <= 1'b0;
      desborde_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcd_q          <= bcd_d;
      bin_q          <= bin_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      reg_binario_q  <= reg_binario_d;
      ocupado_q      <= ocupado_d;
      listo_q        <= listo_d;
      error_digito_q <= error_digito_d;
      desborde_q     <= desborde_d;
    end
  end

  assign bus.reg_binario  = reg_binario_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.listo        = listo_q;
  assign bus.error_digito = error_digito_q;
  assign bus.desborde     = desborde_q;
endmodule

// File: tb/tb_conversor_reg_bcd_reg_nbits.sv
// Scoreboard bench: stimulus pushes model results at each accept edge, a monitor pops on every listo.
// The model works on decimal values directly, not on the shift/adjust algorithm.
module tb_conversor_reg_bcd_reg_nbits;
  localparam int N = 16;

  typedef struct {
    logic [N-1:0] res;
    bit           err;
    bit           ovf;
    int           acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   accepts;
  int   listo_count;
  logic [N-1:0] last_res;
  exp_t q[$];

  conversor_reg_bcd_reg_nbits_if #(.TAM_REG_BIN(N)) bus ();

  conversor_reg_bcd_reg_nbits #(.TAM_REG_BIN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  // Reference: decimal value of the digits, then range and validity rules
  function automatic exp_t model(input logic [N+3:0] bcd);
    exp_t   e;
    longint val;
    longint w;
    logic [3:0] d;
    val = 0;
    w = 1;
    e.err = 1'b0;
    for (int i = 0; i < (N + 4) / 4; i++) begin
      d = bcd[4*i +: 4];
      if (d > 4'd9) e.err = 1'b1;
      val += longint'(d) * w;
      w *= 10;
    end
    e.ovf = !e.err && (val >= (64'd1 << N));
    e.res = e.err ? '0 : N'(val % (64'd1 << N));
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [N+3:0] toBcd(input int unsigned v);
    logic [N+3:0] b;
    int unsigned  t;
    b = '0;
    t = v;
    for (int i = 0; i < (N + 4) / 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.ocupado) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportFail("wait_ocupado_low");
  endtask

  task automatic waitDone();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportFail("wait_listo");
  endtask

  task automatic applyStimulus(input logic [N+3:0] bcd);
    exp_t e;
    waitIdle();
    bus.inicio  = 1'b1;
    bus.reg_BCD = bcd;
    @(posedge clk);
    #1;
    e = model(bcd);
    e.acc = cyc;
    q.push_back(e);
    accepts++;
    @(negedge clk);
    bus.inicio  = 1'b0;
    bus.reg_BCD = 20'($urandom);
  endtask

  // Monitor: compares each listo pulse against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_res = '0;
      end else if (bus.listo) begin
        listo_count++;
        if (q.size() == 0) begin
          checkOutput("unexpected_listo", 32'(bus.listo), 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput("reg_binario", 32'(bus.reg_binario), 32'(e.res));
          checkOutput("error_digito", 32'(bus.error_digito), 32'(e.err));
          checkOutput("desborde", 32'(bus.desborde), 32'(e.ovf));
          checkOutput("ocupado_at_listo", 32'(bus.ocupado), 32'd0);
          checkOutput("latency", 32'(cyc - e.acc), e.err ? 32'd1 : 32'(N + 1));
          last_res = e.res;
        end
      end else begin
        checkOutput("reg_binario_hold", 32'(bus.reg_binario), 32'(last_res));
      end
    end
  end

  initial begin
    exp_t e;
    logic [N+3:0] v;
    int   aborted;
    checks      = 0;
    failures    = 0;
    accepts     = 0;
    listo_count = 0;
    last_res    = '0;
    reset       = 1'b1;
    bus.inicio  = 1'b0;
    bus.reg_BCD = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_reg_binario", 32'(bus.reg_binario), 32'd0);
    checkOutput("rst_ocupado", 32'(bus.ocupado), 32'd0);
    checkOutput("rst_listo", 32'(bus.listo), 32'd0);
    checkOutput("rst_error_digito", 32'(bus.error_digito), 32'd0);
    checkOutput("rst_desborde", 32'(bus.desborde), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(20'h00255);
    waitDone();
    applyStimulus(20'h65535);
    applyStimulus(20'h65536);
    applyStimulus(20'h1A000);
    applyStimulus(20'h99999);
    applyStimulus(20'h00000);
    applyStimulus(20'h0000F);
    waitDone();

    $display("[TB] start pulses while busy are ignored");
    applyStimulus(20'h00255);
    repeat (3) @(negedge clk);
    bus.inicio  = 1'b1;
    bus.reg_BCD = 20'h00999;
    repeat (2) @(negedge clk);
    bus.inicio  = 1'b0;
    waitDone();

    $display("[TB] inicio held high, back-to-back");
    waitIdle();
    bus.inicio  = 1'b1;
    bus.reg_BCD = 20'h00000;
    @(posedge clk);
    #1;
    e = model(20'h00000);
    e.acc = cyc;
    q.push_back(e);
    accepts++;
    @(negedge clk);
    bus.reg_BCD = 20'h01234;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.listo) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) reportFail("b2b_first_listo");
    end
    @(posedge clk);
    #1;
    e = model(20'h01234);
    e.acc = cyc;
    q.push_back(e);
    accepts++;
    checkOutput("b2b_second_accept", 32'(bus.ocupado), 32'd1);
    @(negedge clk);
    bus.inicio = 1'b0;
    waitDone();

    $display("[TB] reset mid conversion");
    applyStimulus(20'h04096);
    repeat (7) @(negedge clk);
    reset   = 1'b1;
    aborted = q.size();
    q.delete();
    accepts -= aborted;
    @(posedge clk);
    #1;
    checkOutput("abort_ocupado", 32'(bus.ocupado), 32'd0);
    checkOutput("abort_listo", 32'(bus.listo), 32'd0);
    checkOutput("abort_reg_binario", 32'(bus.reg_binario), 32'd0);
    checkOutput("abort_error_digito", 32'(bus.error_digito), 32'd0);
    checkOutput("abort_desborde", 32'(bus.desborde), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    applyStimulus(20'h04096);
    waitDone();

    $display("[TB] random valid operands");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(toBcd($urandom_range(0, 65535)));
    end
    $display("[TB] random raw patterns");
    for (int i = 0; i < 40; i++) begin
      v = 20'($urandom);
      applyStimulus(v);
    end
    waitDone();
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(q.size()), 32'd0);
    checkOutput("listo_per_accept", 32'(listo_count), 32'(accepts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
